// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C encodings, bus levels and address helper
package i2c_pkg;

  localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
  localparam logic [2:0] ST_ADDR_ENC      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK_ENC  = 3'd2;
  localparam logic [2:0] ST_TX_BYTE_ENC   = 3'd3;
  localparam logic [2:0] ST_RX_ACK_ENC    = 3'd4;
  localparam logic [2:0] ST_WAIT_STOP_ENC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = ST_IDLE_ENC,
    ST_ADDR      = ST_ADDR_ENC,
    ST_ADDR_ACK  = ST_ADDR_ACK_ENC,
    ST_TX_BYTE   = ST_TX_BYTE_ENC,
    ST_RX_ACK    = ST_RX_ACK_ENC,
    ST_WAIT_STOP = ST_WAIT_STOP_ENC
  } i2c_state_t;

  localparam logic       I2C_RW_READ      = 1'b1;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'b1111111;
  localparam logic [3:0] I2C_BYTE_BITS    = 4'd8;

  // Address byte is {addr[6:0], rw}; only reads are answered by this target.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
    return (addr_byte[7:1] == addr) && (addr_byte[0] == I2C_RW_READ);
  endfunction

endpackage

// File: rtl/i2c_slave_tx_if.sv
// rtl/i2c_slave_tx_if.sv - bus pins and word/status handshake of the read-only I2C target
interface i2c_slave_tx_if;

  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic [15:0] tx_data;
  logic        busy;
  logic        addr_hit;
  logic        done;
  logic        nack_err;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, busy, addr_hit, done, nack_err
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, busy, addr_hit, done, nack_err
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizers with edge, START and STOP detection
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  // Flops reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
      r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_scl      = w_scl;
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl & r_scl_prev;
  assign o_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_slave_tx.sv
// rtl/i2c_slave_tx.sv - I2C read target returning one 16-bit word MSB first
module i2c_slave_tx
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            resetn,
  i2c_slave_tx_if.slave   bus
);

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_drive;
  logic [7:0] w_addr_byte;

  i2c_state_t r_state;
  logic [3:0] r_bit_cnt;
  logic       r_byte_idx;
  logic [6:0] r_addr_sr;
  logic [15:0] r_tx_sr;
  logic       r_sda_oe;
  logic       r_busy;
  logic       r_addr_hit;
  logic       r_done;
  logic       r_nack_err;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .resetn     (resetn),
    .i_scl      (bus.scl_in),
    .i_sda      (bus.sda_in),
    .o_scl      (w_scl),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  // SDA may only move while synchronized SCL is low.
  assign w_drive     = w_scl_fall & ~w_scl;
  assign w_addr_byte = {r_addr_sr, w_sda};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 4'd0;
      r_byte_idx <= 1'b0;
      r_addr_sr  <= 7'd0;
      r_tx_sr    <= 16'd0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_addr_hit <= 1'b0;
      r_done     <= 1'b0;
      r_nack_err <= 1'b0;
    end else begin
      r_addr_hit <= 1'b0;
      r_done     <= 1'b0;
      r_nack_err <= 1'b0;
      if (w_stop) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_start) begin
        r_state   <= ST_ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
          end
          ST_ADDR: begin
            if (w_scl_rise && r_bit_cnt < I2C_BYTE_BITS) begin
              r_addr_sr <= w_addr_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == I2C_BYTE_BITS - 4'd1) begin
                if (addr_match(w_addr_byte, SLAVE_ADDR)) begin
                  r_addr_hit <= 1'b1;
                  r_tx_sr    <= bus.tx_data;
                  r_byte_idx <= 1'b0;
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end
            end else if (w_drive && r_bit_cnt == I2C_BYTE_BITS) begin
              r_sda_oe  <= ~I2C_ACK;
              r_state   <= ST_ADDR_ACK;
              r_bit_cnt <= 4'd0;
            end
          end
          ST_ADDR_ACK: begin
            // bit_cnt=1 marks that the ACK clock's high phase has been seen.
            if (w_scl_rise) begin
              r_bit_cnt <= 4'd1;
            end else if (w_drive && r_bit_cnt == 4'd1) begin
              r_sda_oe  <= ~r_tx_sr[15];
              r_state   <= ST_TX_BYTE;
              r_bit_cnt <= 4'd0;
            end
          end
          ST_TX_BYTE: begin
            if (w_scl_rise && r_bit_cnt < I2C_BYTE_BITS) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_drive && r_bit_cnt != 4'd0) begin
              // The 8th shift also lines up the second byte's MSB at bit 15.
              r_tx_sr <= {r_tx_sr[14:0], 1'b0};
              if (r_bit_cnt == I2C_BYTE_BITS) begin
                r_sda_oe  <= 1'b0;
                r_state   <= ST_RX_ACK;
                r_bit_cnt <= 4'd0;
              end else begin
                r_sda_oe <= ~r_tx_sr[14];
              end
            end
          end
          ST_RX_ACK: begin
            if (w_scl_rise) begin
              if (r_byte_idx) begin
                r_done  <= 1'b1;
                r_state <= ST_WAIT_STOP;
              end else if (w_sda == I2C_ACK) begin
                r_byte_idx <= 1'b1;
                r_bit_cnt  <= 4'd1;
              end else begin
                r_nack_err <= 1'b1;
                r_state    <= ST_WAIT_STOP;
              end
            end else if (w_drive && r_bit_cnt == 4'd1) begin
              r_sda_oe  <= ~r_tx_sr[15];
              r_state   <= ST_TX_BYTE;
              r_bit_cnt <= 4'd0;
            end
          end
          ST_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe   = r_sda_oe;
  assign bus.busy     = r_busy;
  assign bus.addr_hit = r_addr_hit;
  assign bus.done     = r_done;
  assign bus.nack_err = r_nack_err;

endmodule

// File: doc/i2c_slave_tx.md
Name: i2c_slave_tx

Overview:
I2C target (responder) that answers a master read transaction and returns one 16-bit word, MSB first, as two bytes. Sits on the same open-drain SCL/SDA pair as the design's I2C master. Used as an on-chip sensor model and as a loop-back partner for master bring-up.
The block oversamples SCL/SDA on the system clock, detects START and STOP, matches the 7-bit address, ACKs, and shifts out the word. It never drives SCL; clock stretching is not supported.

Parameters:
SLAVE_ADDR, 7'b1111111, 7-bit target address compared against the first byte after START.
SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronizers (minimum 2).

Ports:
clk  input  1  system clock; all logic on rising edge.
resetn  input  1  asynchronous active-low reset.
scl_in  input  1  bus SCL level (resolved wire, pulled up).
sda_in  input  1  bus SDA level (resolved wire, pulled up).
sda_oe  output  1  1 = pull SDA low; 0 = release (bus reads 1).
tx_data  input  16  word to return; sampled once per transaction.
busy  output  1  high from a detected START until STOP or return to IDLE.
addr_hit  output  1  one-cycle pulse when the address matches with R/W=1.
done  output  1  one-cycle pulse when both bytes are sent and the master's 9th bit is sampled.
nack_err  output  1  one-cycle pulse when the master NACKs the first byte.

Behaviour:
- Reset values: sda_oe=0, busy=0, addr_hit=0, done=0, nack_err=0. State=IDLE, counters=0.
- Reset is asynchronous, so asserting resetn mid-transfer releases SDA at once.
- Input conditioning:
  - scl_in and sda_in each pass through SYNC_STAGES flops, then one more flop for the previous value.
  - scl_rise/scl_fall: synchronized SCL changes 0->1 / 1->0.
  - start_det: synchronized SDA falls while SCL=1.
  - stop_det: synchronized SDA rises while SCL=1.
- Timing rules:
  - All SDA changes happen only on scl_fall, at most SYNC_STAGES+2 clk cycles after the bus SCL edge.
  - Sampling happens on scl_rise.
  - Requires SCL half-period > SYNC_STAGES+4 clk cycles.
- States: IDLE, ADDR, ADDR_ACK, TX_BYTE, RX_ACK, WAIT_STOP.
- Global overrides, evaluated before per-state logic:
  - stop_det in any state -> IDLE, sda_oe=0, busy=0.
  - start_det in any state (including repeated START) -> ADDR, bit_cnt=0, sda_oe=0, busy=1.
- IDLE: sda_oe=0; waits for start_det.
- ADDR:
  - Shift sda into an 8-bit register on each scl_rise, MSB first; bit_cnt counts 0..7.
  - After the 8th rise, compare bits[7:1] with SLAVE_ADDR and check bit[0]==1 (read).
  - Match: pulse addr_hit, latch tx_data into the 16-bit shift register, set byte_idx=0.
  - The next scl_fall sets sda_oe=1 (ACK) and moves to ADDR_ACK.
  - Mismatch or R/W=0: keep sda_oe=0 (NACK) and go to WAIT_STOP. No pulses.
- ADDR_ACK:
  - ACK is held through the 9th clock high phase.
  - On the following scl_fall, drive data MSB: sda_oe = ~shift[15]. Go to TX_BYTE with bit_cnt=0.
- TX_BYTE:
  - Each scl_rise increments bit_cnt.
  - Each scl_fall after a rise with bit_cnt<8 shifts left one and drives sda_oe = ~shift[15].
  - On the scl_fall after the 8th rise, sda_oe=0 (release for master ACK) and go to RX_ACK.
- RX_ACK: on scl_rise, sample sda.
  - byte_idx=0 and sda=0 (ACK): byte_idx=1. On the next scl_fall drive the bit-15 position of the second byte (original tx_data[7]) and go to TX_BYTE.
  - byte_idx=0 and sda=1 (NACK): pulse nack_err, go to WAIT_STOP.
  - byte_idx=1: pulse done regardless of ACK/NACK (master NACKs the last byte normally), go to WAIT_STOP.
- WAIT_STOP: sda_oe=0; leaves only on stop_det or start_det.
- Counters:
  - bit_cnt is 4 bits, saturating use 0..8.
  - byte_idx is 1 bit.
  - No wrap: a third byte is never sent.
- Simultaneous events: stop_det takes precedence over start_det, which takes precedence over scl edges in the same cycle.
- Self-check: sda_oe is never changed while synchronized SCL=1, except by reset or a STOP/START release.
- tx_data changes after addr_hit have no effect until the next transaction.

Decomposition:
- Shared package i2c_pkg:
  - state encoding localparams: 3-bit, IDLE=0 .. WAIT_STOP=5;
  - I2C_RW_READ=1'b1;
  - ACK=1'b0 and NACK=1'b1 bus levels;
  - default SLAVE_ADDR.
- One sub-module, i2c_bus_sync: SCL/SDA synchronizers plus scl_rise, scl_fall, start_det, stop_det, and synchronized levels. It is reusable by the master for SDA sampling.

Test Plan:
1. Master reads address 7'h7F, tx_data=16'hA5C3 -> addr_hit pulse after the 8th SCL rise; ACK low on the 9th clock; SDA bits 1010_0101 then 1100_0011; done pulse; busy falls on STOP.
2. Master sends address 7'h2A with SLAVE_ADDR=7'h7F -> SDA released on the 9th clock (NACK), no pulses, sda_oe stays 0 until STOP.
3. Address 7'h7F with R/W=0 -> NACK, WAIT_STOP, no addr_hit.
4. Master NACKs the first byte of 16'h00FF -> nack_err pulse; sda_oe=0 for the following SCL clocks; no done.
5. Repeated START after the first data byte, then a new read with tx_data=16'h1234 -> restart in ADDR; second transfer returns 0x12, 0x34; done pulse once.
6. resetn driven low mid-byte while sda_oe=1 -> sda_oe=0 in the same cycle, all outputs at reset values; the next START/read completes normally.
